// File: rtl/arbitrated_memory.sv
// Shared single-port main memory with an N-port round-robin/fixed arbiter, framebuffer VRAM mirror and VGA scan-out port.
// Latency: ack (and read data) one cycle after grant; backpressure: losers hold req until ack, a just-acked port is masked one cycle.
module arbitrated_memory #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int MEMORY_SIZE   = 4096,
  parameter int FB_OFFSET     = 'hF00,
  parameter int FB_LENGTH     = 256,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_PORTS-1:0]            ack,
  output logic [DATA_WIDTH-1:0]           rdata,
  input  logic [$clog2(FB_LENGTH)-1:0]    vga_addr,
  output logic [DATA_WIDTH-1:0]           vga_data
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam int VW = $clog2(FB_LENGTH);
  localparam logic [ADDR_WIDTH:0] MEM_END = (ADDR_WIDTH+1)'(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH:0] FB_LO   = (ADDR_WIDTH+1)'(FB_OFFSET);
  localparam logic [ADDR_WIDTH:0] FB_HI   = (ADDR_WIDTH+1)'(FB_OFFSET + FB_LENGTH);

  logic [DATA_WIDTH-1:0] mem  [MEMORY_SIZE];
  logic [DATA_WIDTH-1:0] vram [FB_LENGTH];

  logic [NUM_PORTS-1:0]  elig;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         cand;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_vld;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;
  logic                  in_range;
  logic                  fb_hit;
  logic [MW-1:0]         mem_idx;
  logic [VW-1:0]         vram_idx;

  // Masking on ack prevents double service; gating on rst_n keeps any access from completing during reset.
  assign elig = req & ~ack & {NUM_PORTS{rst_n}};

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (PRIORITY_MODE != 0) ? PW'(k) : PW'((int'(ptr) + k) % NUM_PORTS);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign sel_addr  = addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_we    = we[gnt_idx];
  assign in_range  = {1'b0, sel_addr} < MEM_END;
  assign fb_hit    = ({1'b0, sel_addr} >= FB_LO) && ({1'b0, sel_addr} < FB_HI);
  assign mem_idx   = sel_addr[MW-1:0];
  assign vram_idx  = VW'(sel_addr - FB_LO[ADDR_WIDTH-1:0]);

  // Array contents survive reset; only control state below is cleared.
  always_ff @(posedge clk) begin
    if (gnt_vld && sel_we) begin
      if (in_range) mem[mem_idx] <= sel_wdata;
      if (fb_hit)   vram[vram_idx] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= '0;
      rdata    <= '0;
      vga_data <= '0;
      ptr      <= '0;
    end else begin
      ack      <= '0;
      vga_data <= vram[vga_addr];
      if (gnt_vld) begin
        ack <= NUM_PORTS'(1) << gnt_idx;
        if (PRIORITY_MODE == 0) ptr <= (int'(gnt_idx) == NUM_PORTS-1) ? '0 : gnt_idx + 1'b1;
        if (!sel_we) rdata <= in_range ? mem[mem_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_arbitrated_memory.sv
// Bench for arbitrated_memory: directed vector table, round-robin/fixed order sequences, reset mid-stream and random traffic vs. a reference model.
module tb_arbitrated_memory;
  localparam int NP  = 3;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int MSZ = 4000;
  localparam int FBO = 'hE00;
  localparam int FBL = 256;

  logic clk = 1'b0;
  logic rst_n;

  logic [NP-1:0]    req = '0, we = '0, ack;
  logic [NP*AW-1:0] addr = '0;
  logic [NP*DW-1:0] wdata = '0;
  logic [DW-1:0]    rdata, vga_data;
  logic [7:0]       vga_addr = '0;

  logic [NP-1:0]    fx_req = '0, fx_we = '0, fx_ack;
  logic [NP*AW-1:0] fx_addr = '0;
  logic [NP*DW-1:0] fx_wdata = '0;
  logic [DW-1:0]    fx_rdata, fx_vga_data;
  logic [7:0]       fx_vga_addr = '0;

  arbitrated_memory #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_SIZE(MSZ),
                      .FB_OFFSET(FBO), .FB_LENGTH(FBL), .PRIORITY_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .vga_addr(vga_addr), .vga_data(vga_data));

  arbitrated_memory #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_SIZE(MSZ),
                      .FB_OFFSET(FBO), .FB_LENGTH(FBL), .PRIORITY_MODE(1)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req(fx_req), .we(fx_we), .addr(fx_addr), .wdata(fx_wdata),
    .ack(fx_ack), .rdata(fx_rdata), .vga_addr(fx_vga_addr), .vga_data(fx_vga_data));

  always #5 clk = ~clk;

  int checks, errors;

  // Reference model state
  logic [NP-1:0] m_ack;
  int            m_ptr;
  logic [DW-1:0] m_rdata;
  bit            m_rd_known;
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] vram_m [FBL];
  bit            vram_k [FBL];

  typedef struct {
    int          port;
    bit          wr;
    logic [11:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp_rd;
    logic [7:0]  vga_a;
    logic [7:0]  exp_vga;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of traffic: winner = eligible port nearest the pointer going upward (mod NP).
  task automatic tick();
    int g, best, d, ai;
    logic [DW-1:0] wd, exp_vga;
    bit vk;
    g = -1;
    best = NP;
    for (int c = 0; c < NP; c++) begin
      if (req[c] && !m_ack[c]) begin
        d = (c - m_ptr + NP) % NP;
        if (d < best) begin
          best = d;
          g = c;
        end
      end
    end
    vk = vram_k[vga_addr];
    exp_vga = vram_m[vga_addr];
    m_ack = '0;
    if (g >= 0) begin
      ai = int'(addr[g*AW +: AW]);
      wd = wdata[g*DW +: DW];
      m_ack[g] = 1'b1;
      m_ptr = (g + 1) % NP;
      if (we[g]) begin
        if (ai < MSZ) mem_m[ai] = wd;
        if (ai >= FBO && ai < FBO + FBL) begin
          vram_m[ai-FBO] = wd;
          vram_k[ai-FBO] = 1'b1;
        end
      end else if (ai >= MSZ) begin
        m_rdata = '0;
        m_rd_known = 1'b1;
      end else if (mem_m.exists(ai)) begin
        m_rdata = mem_m[ai];
        m_rd_known = 1'b1;
      end else begin
        m_rd_known = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("ack", 32'(ack), 32'(m_ack));
    if (m_rd_known) chk("rdata", 32'(rdata), 32'(m_rdata));
    if (vk) chk("vga_data", 32'(vga_data), 32'(exp_vga));
  endtask

  task automatic access(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd);
    int n;
    if (ack[p]) tick();
    req[p] = 1'b1;
    we[p] = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack[p] && n < 8);
    chk("access_latency", 32'(n), 32'd1);
    rd = rdata;
    req[p] = 1'b0;
  endtask

  task automatic new_req(input int p);
    int r;
    logic [AW-1:0] a;
    r = $urandom_range(9, 0);
    if (r < 4)      a = AW'(12'h100 + $urandom_range(15, 0));
    else if (r < 8) a = AW'(FBO + $urandom_range(FBL-1, 0));
    else            a = AW'(MSZ + $urandom_range(95, 0));
    req[p] = 1'b1;
    we[p] = 1'($urandom_range(1, 0));
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [DW-1:0] rd;
    int fx_exp [7];
    checks = 0;
    errors = 0;
    m_ack = '0;
    m_ptr = 0;
    m_rdata = '0;
    m_rd_known = 1'b1;
    for (int i = 0; i < FBL; i++) vram_k[i] = 1'b0;

    vt[0]  = '{0, 1'b1, 12'h200, 8'hA2, 8'h00, 8'h03, 8'h59};
    vt[1]  = '{0, 1'b0, 12'h200, 8'h00, 8'hA2, 8'h03, 8'h59};
    vt[2]  = '{1, 1'b1, 12'hE03, 8'h5A, 8'h00, 8'h03, 8'h5A};
    vt[3]  = '{1, 1'b1, 12'h300, 8'h11, 8'h00, 8'h03, 8'h5A};
    vt[4]  = '{2, 1'b0, 12'h300, 8'h00, 8'h11, 8'hFF, 8'hA5};
    vt[5]  = '{0, 1'b1, 12'hFA0, 8'h77, 8'h00, 8'hFF, 8'hA5};
    vt[6]  = '{1, 1'b0, 12'hFA0, 8'h00, 8'h00, 8'hFF, 8'hA5};
    vt[7]  = '{2, 1'b1, 12'hEFF, 8'hC3, 8'h00, 8'hFF, 8'hC3};
    vt[8]  = '{0, 1'b1, 12'hF00, 8'h3C, 8'h00, 8'h00, 8'h5A};
    vt[9]  = '{1, 1'b0, 12'hF00, 8'h00, 8'h3C, 8'h00, 8'h5A};
    vt[10] = '{2, 1'b0, 12'hE03, 8'h00, 8'h5A, 8'h03, 8'h5A};
    vt[11] = '{1, 1'b0, 12'hE00, 8'h00, 8'h5A, 8'h10, 8'h4A};
    fx_exp = '{1, 4, 1, 4, 1, 2, 1};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_vga", 32'(vga_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority: 0 and 2 alternate; 1 joins and wins only while 0 is masked.
    fx_req = 3'b101;
    fx_we = 3'b111;
    fx_addr = {12'h012, 12'h011, 12'h010};
    for (int k = 0; k < 7; k++) begin
      if (k == 4) fx_req = 3'b111;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("fx_order%0d", k), 32'(fx_ack), 32'(fx_exp[k]));
    end
    fx_req = '0;

    // Round-robin with all ports held from pointer 0.
    req = 3'b111;
    we = 3'b111;
    addr = {12'h102, 12'h101, 12'h100};
    wdata = {8'h03, 8'h02, 8'h01};
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("rr_order%0d", k), 32'(ack), 32'(1 << (k % 3)));
    end
    req = '0;
    tick();

    for (int i = 0; i < FBL; i++) access(i % 3, 1'b1, AW'(FBO + i), DW'(i) ^ 8'h5A, rd);

    for (int i = 0; i < 12; i++) begin
      vga_addr = vt[i].vga_a;
      access(vt[i].port, vt[i].wr, vt[i].a, vt[i].wd, rd);
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp_rd));
      tick();
      chk($sformatf("vec%0d_vga", i), 32'(vga_data), 32'(vt[i].exp_vga));
    end

    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (ack[p]) begin
          if ($urandom_range(1, 0) == 1) new_req(p);
          else req[p] = 1'b0;
        end else if (req[p]) begin
          if ($urandom_range(19, 0) == 0) req[p] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          new_req(p);
        end
      end
      vga_addr = 8'($urandom);
      tick();
    end

    // Reset while port 1's read ack is high.
    req = '0;
    tick();
    tick();
    req[1] = 1'b1;
    we[1] = 1'b0;
    addr[1*AW +: AW] = 12'h200;
    tick();
    chk("pre_reset_ack", 32'(ack), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ack", 32'(ack), 32'd0);
    chk("async_reset_rdata", 32'(rdata), 32'd0);
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[0*AW +: AW] = 12'h200;
    wdata[0*DW +: DW] = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("in_reset_ack", 32'(ack), 32'd0);
    end
    req = '0;
    rst_n = 1'b1;
    m_ack = '0;
    m_ptr = 0;
    m_rdata = '0;
    m_rd_known = 1'b1;
    req = 3'b110;
    we = 3'b000;
    addr[2*AW +: AW] = 12'hE03;
    tick();
    chk("post_reset_grant", 32'(ack), 32'd2);
    chk("post_reset_data", 32'(rdata), 32'hA2);
    req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
